clk_div_multi: RTL and testbench

//   Parametrised, multi-channel successor to the single fixed-ratio clock divider.

---
 rtl/clk_div_multi_pkg.sv | 26 ++
 rtl/clk_div_chan.sv | 103 ++++++++++
 rtl/clk_div_multi.sv | 51 +++++
 tb/tb_clk_div_multi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// ============================================================================
// Module   : clk_div_multi_pkg
// Purpose  : Shared constants, channel FSM encoding and helpers for clk_div_multi
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

package clk_div_multi_pkg;

    localparam int c_CNT_W        = 24;
    localparam int c_DEFAULT_HALF = 49_999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } chan_state_t;

    // A single-channel build still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// Module   : clk_div_chan
// Purpose  : One divider channel: half-period counter, shadow/active ratio,
//            IDLE/RUN/STOP control and registered SLOW/TICK/RUNNING outputs
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int               CNT_W        = c_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(c_DEFAULT_HALF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_half,
    output logic             o_slow,
    output logic             o_tick,
    output logic             o_running
);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_slow;
    logic             r_tick;
    logic             r_running;
    logic             w_wrap;

    assign w_wrap = (r_cnt == r_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_active  <= DEFAULT_HALF;
            r_shadow  <= DEFAULT_HALF;
            r_slow    <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_we) begin
                r_shadow <= i_half;
            end
            case (r_state)
                IDLE: begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    r_slow   <= 1'b0;
                    if (i_en) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (!i_en && !r_slow) begin
                        // Stopping in the low phase cannot produce a runt.
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_cnt     <= '0;
                    end else if (w_wrap) begin
                        r_cnt  <= '0;
                        r_slow <= ~r_slow;
                        if (!r_slow) begin
                            r_tick  <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            // End of a full period: the only safe point to retune.
                            r_active <= r_shadow;
                            if (!i_en) begin
                                r_state   <= IDLE;
                                r_running <= 1'b0;
                            end else begin
                                r_state <= RUN;
                            end
                        end
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= i_en ? RUN : STOP;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_cnt     <= '0;
                    r_slow    <= 1'b0;
                end
            endcase
        end
    end

    assign o_slow    = r_slow;
    assign o_tick    = r_tick;
    assign o_running = r_running;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Purpose  : CHANNELS independent programmable clock dividers with clock
//            enables; decodes the shared config port into per-channel writes
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int               CHANNELS     = 4,
    parameter int               CNT_W        = c_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(c_DEFAULT_HALF),
    localparam int              SEL_W        = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_cfg_we,
    input  logic [SEL_W-1:0]    i_cfg_sel,
    input  logic [CNT_W-1:0]    i_cfg_half,
    output logic [CHANNELS-1:0] o_slow,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_running
);

    // Out-of-range selects match no channel and are dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic w_we;

        assign w_we = i_cfg_we && (i_cfg_sel == SEL_W'(g));

        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (i_en[g]),
            .i_we      (w_we),
            .i_half    (i_cfg_half),
            .o_slow    (o_slow[g]),
            .o_tick    (o_tick[g]),
            .o_running (o_running[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module   : tb_clk_div_multi
// Purpose  : Self-checking bench for clk_div_multi against a timestamp model
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

    localparam int CH = 3;
    localparam int H0 = 20;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          we;
    logic [1:0]    sel;
    logic [23:0]   half;
    logic [CH-1:0] o_slow;
    logic [CH-1:0] o_tick;
    logic [CH-1:0] o_running;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: each channel remembers when its current phase began.
    int m_h  [CH];
    int m_sh [CH];
    int m_t0 [CH];
    bit m_run  [CH];
    bit m_slow [CH];
    bit m_tick [CH];

    clk_div_multi #(
        .CHANNELS     (CH),
        .CNT_W        (24),
        .DEFAULT_HALF (24'(H0))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_cfg_we   (we),
        .i_cfg_sel  (sel),
        .i_cfg_half (half),
        .o_slow     (o_slow),
        .o_tick     (o_tick),
        .o_running  (o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_h[c] = H0; m_sh[c] = H0; m_t0[c] = 0;
            m_run[c] = 0; m_slow[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            m_tick[c] = 0;
            if (!m_run[c]) begin
                m_h[c] = m_sh[c];
                if (en[c]) begin
                    m_run[c] = 1;
                    m_t0[c]  = cyc;
                end
            end else if (!en[c] && !m_slow[c]) begin
                m_run[c] = 0;
            end else if (cyc - m_t0[c] == m_h[c] + 1) begin
                m_slow[c] = !m_slow[c];
                m_t0[c]   = cyc;
                if (m_slow[c]) begin
                    m_tick[c] = 1;
                end else begin
                    m_h[c] = m_sh[c];
                    if (!en[c]) m_run[c] = 0;
                end
            end
            if (we && int'(sel) == c) m_sh[c] = int'(half);
        end
    endtask

    task automatic step();
        logic [CH-1:0] es, et, er;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            es[c] = m_slow[c]; et[c] = m_tick[c]; er[c] = m_run[c];
        end
        check("model_slow", 32'(o_slow), 32'(es));
        check("model_tick", 32'(o_tick), 32'(et));
        check("model_running", 32'(o_running), 32'(er));
    endtask

    task automatic write(input int s, input int h);
        we = 1'b1; sel = 2'(s); half = 24'(h);
        step();
        we = 1'b0;
    endtask

    // kind 0 waits on SLOW, kind 1 on RUNNING; returns the cycle stamp.
    task automatic wait_level(input int kind, input int c, input logic lvl, output int t);
        int n;
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (kind == 0) ? o_slow[c] : o_running[c];
        end while (v !== lvl && n < 300);
        check($sformatf("wait_k%0d_ch%0d", kind, c), 32'(v), 32'(lvl));
        t = cyc;
    endtask

    task automatic next_fall(input int c, output int t);
        int tr;
        wait_level(0, c, 1'b1, tr);
        wait_level(0, c, 1'b0, t);
    endtask

    initial begin
        int t_run, r, f1, f2, f3, f4, f5, f6, f7, n;

        rst_n = 1'b0; en = '0; we = 1'b0; sel = '0; half = '0;
        model_reset();
        #2;
        check("reset_slow", 32'(o_slow), 0);
        check("reset_tick", 32'(o_tick), 0);
        check("reset_running", 32'(o_running), 0);
        step(); step();
        rst_n = 1'b1;

        // Basic division, H=3
        write(0, 3);
        en[0] = 1'b1;
        wait_level(1, 0, 1'b1, t_run);
        wait_level(0, 0, 1'b1, r);
        check("t1_first_rise", r - t_run, 4);
        wait_level(0, 0, 1'b0, f1);
        check("t1_high", f1 - r, 4);
        wait_level(0, 0, 1'b1, f2);
        check("t1_period", f2 - r, 8);

        // H=0 on channel 1
        write(1, 0);
        en[1] = 1'b1;
        wait_level(1, 1, 1'b1, t_run);
        wait_level(0, 1, 1'b1, r);
        check("t2_first_rise", r - t_run, 1);
        wait_level(0, 1, 1'b0, f1);
        wait_level(0, 1, 1'b1, f2);
        check("t2_period", f2 - r, 2);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n += int'(o_tick[1]);
        end
        check("t2_ticks", n, 5);

        // Ratio change mid high phase
        next_fall(0, f1);
        wait_level(0, 0, 1'b1, r);
        step();
        write(0, 1);
        wait_level(0, 0, 1'b0, f2);
        check("t3_mid_old", f2 - f1, 8);
        next_fall(0, f3);
        check("t3_mid_new", f3 - f2, 4);
        write(0, 3);
        next_fall(0, f4);
        check("t3_apply3", f4 - f3, 4);
        // Write landing exactly on the 1->0 edge
        for (int i = 0; i < 7; i++) step();
        we = 1'b1; sel = 2'd0; half = 24'd1;
        step();
        we = 1'b0;
        check("t3_edge_fall", 32'(o_slow[0]), 0);
        f5 = cyc;
        check("t3_edge_prev", f5 - f4, 8);
        next_fall(0, f6);
        check("t3_edge_old", f6 - f5, 8);
        next_fall(0, f7);
        check("t3_edge_new", f7 - f6, 4);

        // Stop in the high phase, then in the low phase
        write(0, 3);
        next_fall(0, f1);
        wait_level(0, 0, 1'b1, r);
        step();
        en[0] = 1'b0;
        wait_level(0, 0, 1'b0, f2);
        check("t4_high_hold", f2 - r, 4);
        check("t4_running_fell", 32'(o_running[0]), 0);
        for (int i = 0; i < 4; i++) step();
        check("t4_stays_low", 32'(o_slow[0]), 0);
        en[0] = 1'b1;
        wait_level(0, 0, 1'b1, r);
        wait_level(0, 0, 1'b0, f1);
        step();
        en[0] = 1'b0;
        step();
        check("t4_low_stop_run", 32'(o_running[0]), 0);
        check("t4_low_stop_slow", 32'(o_slow[0]), 0);

        // Asynchronous reset mid-period
        en[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        check("t5_async_slow", 32'(o_slow), 0);
        check("t5_async_tick", 32'(o_tick), 0);
        check("t5_async_running", 32'(o_running), 0);
        model_reset();
        step(); step();
        rst_n = 1'b1;
        wait_level(1, 0, 1'b1, t_run);
        wait_level(0, 0, 1'b1, r);
        check("t5_first_rise", r - t_run, H0 + 1);
        next_fall(0, f1);
        next_fall(0, f2);
        check("t5_period", f2 - f1, 2 * (H0 + 1));

        // Out-of-range select, then a write while idle
        write(3, 5);
        en[2] = 1'b1;
        wait_level(1, 2, 1'b1, t_run);
        wait_level(0, 2, 1'b1, r);
        check("t6_oor_ignored", r - t_run, H0 + 1);
        en[2] = 1'b0;
        wait_level(1, 2, 1'b0, f1);
        write(2, 2);
        step();
        en[2] = 1'b1;
        wait_level(1, 2, 1'b1, t_run);
        wait_level(0, 2, 1'b1, r);
        check("t6_idle_first", r - t_run, 3);
        next_fall(2, f1);
        next_fall(2, f2);
        check("t6_idle_period", f2 - f1, 6);

        // Random enables and writes against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                we   = 1'b1;
                sel  = 2'($urandom_range(0, 3));
                half = 24'($urandom_range(0, 5));
            end
            step();
            we = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
